// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock level FIFO: width helpers and reset values.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A depth of 2 needs one pointer bit, so the pointer never collapses to zero width.
    function automatic int ptr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

    localparam logic RST_EMPTY        = 1'b1;
    localparam logic RST_FULL         = 1'b0;
    localparam logic RST_ALMOST_EMPTY = 1'b1;
    localparam logic RST_ALMOST_FULL  = 1'b0;
    localparam logic RST_ERR_FLAG     = 1'b0;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array with a synchronous write port and a registered, enabled read port.
module sync_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO of arbitrary depth with fill level, almost-full/empty flags and,
// when SYNC_FIFO_ERR_FLAGS_EN is defined, sticky OVERFLOW/UNDERFLOW flags.
module sync_fifo_lvl
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    localparam int CNT_W     = cnt_width(FIFO_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [FIFO_WIDTH-1:0] WR_DATA,
    input  logic                  R_INC,
    output logic [FIFO_WIDTH-1:0] RD_DATA,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [CNT_W-1:0]      LEVEL
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
`endif
);

    localparam int               PTR_W     = ptr_width(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_LVL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL    = CNT_W'(AE_THRESH);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [CNT_W-1:0] level_next;

    assign wr_acc = W_INC & ~FULL;
    assign rd_acc = R_INC & ~EMPTY;

    // Explicit wrap so non-power-of-two depths cycle through exactly FIFO_DEPTH slots.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        level_next = LEVEL;
        if (wr_acc && !rd_acc) begin
            level_next = LEVEL + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            level_next = LEVEL - CNT_W'(1);
        end
    end

    // Flags decode from the next level so they move in lockstep with LEVEL.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr         <= '0;
            rptr         <= '0;
            LEVEL        <= '0;
            EMPTY        <= RST_EMPTY;
            FULL         <= RST_FULL;
            ALMOST_EMPTY <= RST_ALMOST_EMPTY;
            ALMOST_FULL  <= RST_ALMOST_FULL;
        end else begin
            if (wr_acc) begin
                wptr <= ptr_inc(wptr);
            end
            if (rd_acc) begin
                rptr <= ptr_inc(rptr);
            end
            LEVEL        <= level_next;
            EMPTY        <= (level_next == '0);
            FULL         <= (level_next == DEPTH_LVL);
            ALMOST_EMPTY <= (level_next <= AE_LVL);
            ALMOST_FULL  <= (level_next >= AF_LVL);
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OVERFLOW  <= RST_ERR_FLAG;
            UNDERFLOW <= RST_ERR_FLAG;
        end else begin
            if (W_INC && FULL) begin
                OVERFLOW <= 1'b1;
            end
            if (R_INC && EMPTY) begin
                UNDERFLOW <= 1'b1;
            end
        end
    end
`endif

    sync_fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (CLK),
        .rst_n   (RST),
        .wr_en   (wr_acc),
        .wr_addr (wptr),
        .wr_data (WR_DATA),
        .rd_en   (rd_acc),
        .rd_addr (rptr),
        .rd_data (RD_DATA)
    );

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Bench for sync_fifo_lvl: a depth-8 and a depth-5 instance checked against queue models every cycle.
module tb_sync_fifo_lvl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       w_inc   [2];
    logic [7:0] wr_data [2];
    logic       r_inc   [2];

    logic [7:0] rd_data0, rd_data1;
    logic       full0, empty0, af0, ae0;
    logic       full1, empty1, af1, ae1;
    logic [3:0] level0;
    logic [2:0] level1;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       ovf0, udf0, ovf1, udf1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_lvl #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut0 (
        .CLK(clk), .RST(rst_n), .W_INC(w_inc[0]), .WR_DATA(wr_data[0]), .R_INC(r_inc[0]),
        .RD_DATA(rd_data0), .FULL(full0), .EMPTY(empty0), .ALMOST_FULL(af0),
        .ALMOST_EMPTY(ae0), .LEVEL(level0)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .OVERFLOW(ovf0), .UNDERFLOW(udf0)
`endif
    );

    sync_fifo_lvl #(.FIFO_WIDTH(8), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) dut1 (
        .CLK(clk), .RST(rst_n), .W_INC(w_inc[1]), .WR_DATA(wr_data[1]), .R_INC(r_inc[1]),
        .RD_DATA(rd_data1), .FULL(full1), .EMPTY(empty1), .ALMOST_FULL(af1),
        .ALMOST_EMPTY(ae1), .LEVEL(level1)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .OVERFLOW(ovf1), .UNDERFLOW(udf1)
`endif
    );

    // Reference model: a plain queue per instance plus the last value read out.
    int         m_depth [2] = '{8, 5};
    int         m_af    [2] = '{6, 4};
    int         m_ae    [2] = '{2, 1};
    logic [7:0] mq0 [$];
    logic [7:0] mq1 [$];
    logic [7:0] m_rd    [2];
    bit         m_ovf   [2];
    bit         m_udf   [2];

    function automatic int m_size(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    task automatic model_step(input int k);
        int sz;
        bit wa, ra;
        sz = m_size(k);
        wa = w_inc[k] && (sz != m_depth[k]);
        ra = r_inc[k] && (sz != 0);
        if (w_inc[k] && sz == m_depth[k]) m_ovf[k] = 1'b1;
        if (r_inc[k] && sz == 0) m_udf[k] = 1'b1;
        if (ra) begin
            if (k == 0) m_rd[k] = mq0.pop_front();
            else        m_rd[k] = mq1.pop_front();
        end
        if (wa) begin
            if (k == 0) mq0.push_back(wr_data[k]);
            else        mq1.push_back(wr_data[k]);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq0.delete();
            mq1.delete();
            for (int k = 0; k < 2; k++) begin
                m_rd[k]  = 8'h00;
                m_ovf[k] = 1'b0;
                m_udf[k] = 1'b0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, away from the rising edge, compare both instances with the model.
    always @(negedge clk) begin
        check_output("level0", level0, m_size(0));
        check_output("full0", full0, m_size(0) == m_depth[0]);
        check_output("empty0", empty0, m_size(0) == 0);
        check_output("af0", af0, m_size(0) >= m_af[0]);
        check_output("ae0", ae0, m_size(0) <= m_ae[0]);
        check_output("rd_data0", rd_data0, m_rd[0]);
        check_output("level1", level1, m_size(1));
        check_output("level1_max", level1 <= 3'd5, 1);
        check_output("full1", full1, m_size(1) == m_depth[1]);
        check_output("empty1", empty1, m_size(1) == 0);
        check_output("af1", af1, m_size(1) >= m_af[1]);
        check_output("ae1", ae1, m_size(1) <= m_ae[1]);
        check_output("rd_data1", rd_data1, m_rd[1]);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check_output("ovf0", ovf0, m_ovf[0]);
        check_output("udf0", udf0, m_udf[0]);
        check_output("ovf1", ovf1, m_ovf[1]);
        check_output("udf1", udf1, m_udf[1]);
`endif
    end

    // Drive one cycle of requests from a falling edge and return at the next falling edge.
    task automatic apply_stimulus(input int k, input bit w, input logic [7:0] d, input bit r);
        w_inc[k]   = w;
        wr_data[k] = d;
        r_inc[k]   = r;
        @(negedge clk);
        w_inc[k] = 1'b0;
        r_inc[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nw;
        int guard;
        bit w, r;
        for (int k = 0; k < 2; k++) begin
            w_inc[k]   = 1'b0;
            wr_data[k] = 8'h00;
            r_inc[k]   = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_output("rst_level", level0, 0);
        check_output("rst_empty", empty0, 1);
        check_output("rst_full", full0, 0);
        check_output("rst_ae", ae0, 1);
        check_output("rst_af", af0, 0);
        check_output("rst_rd", rd_data0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 1'b1, 8'((i + 1) * 17), 1'b0);
            check_output("fill_level", level0, i + 1);
            if (i == 1) check_output("ae_at2", ae0, 1);
            if (i == 2) check_output("ae_at3", ae0, 0);
            if (i == 4) check_output("af_at5", af0, 0);
            if (i == 5) check_output("af_at6", af0, 1);
            if (i == 6) check_output("full_at7", full0, 0);
            if (i == 7) check_output("full_at8", full0, 1);
        end
        apply_stimulus(0, 1'b1, 8'h99, 1'b0);
        check_output("drop_level", level0, 8);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 1'b0, 8'h00, 1'b1);
            check_output("drain_rd", rd_data0, (i + 1) * 17);
        end
        check_output("drain_empty", empty0, 1);
        apply_stimulus(0, 1'b0, 8'h00, 1'b1);
        check_output("underread_rd", rd_data0, 8'h88);

        apply_stimulus(0, 1'b1, 8'h3C, 1'b1);
        check_output("sim_empty_lvl", level0, 1);
        check_output("sim_empty_rd", rd_data0, 8'h88);
        apply_stimulus(0, 1'b1, 8'h4D, 1'b0);
        apply_stimulus(0, 1'b1, 8'h5E, 1'b0);
        apply_stimulus(0, 1'b1, 8'h6F, 1'b1);
        check_output("sim_mid_lvl", level0, 3);
        check_output("sim_mid_rd", rd_data0, 8'h3C);
        apply_stimulus(0, 1'b0, 8'h00, 1'b1);
        check_output("order_rd1", rd_data0, 8'h4D);
        apply_stimulus(0, 1'b0, 8'h00, 1'b1);
        check_output("order_rd2", rd_data0, 8'h5E);
        apply_stimulus(0, 1'b0, 8'h00, 1'b1);
        check_output("order_rd3", rd_data0, 8'h6F);

        for (int i = 0; i < 8; i++) apply_stimulus(0, 1'b1, 8'(8'hC0 + i), 1'b0);
        apply_stimulus(0, 1'b1, 8'hEE, 1'b1);
        check_output("sim_full_lvl", level0, 7);
        check_output("sim_full_rd", rd_data0, 8'hC0);
        check_output("sim_full_flag", full0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1'b0, 8'h00, 1'b1);
        check_output("pre_rst_lvl", level0, 4);

        #3;
        rst_n = 1'b0;
        #1;
        check_output("async_level", level0, 0);
        check_output("async_empty", empty0, 1);
        check_output("async_full", full0, 0);
        check_output("async_ae", ae0, 1);
        check_output("async_af", af0, 0);
        check_output("async_rd", rd_data0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(0, 1'b1, 8'hA5, 1'b0);
        apply_stimulus(0, 1'b0, 8'h00, 1'b1);
        check_output("post_rst_rd", rd_data0, 8'hA5);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        apply_stimulus(0, 1'b0, 8'h00, 1'b1);
        check_output("udf_set", udf0, 1);
        for (int i = 0; i < 9; i++) apply_stimulus(0, 1'b1, 8'(i), 1'b0);
        check_output("ovf_set", ovf0, 1);
        apply_stimulus(0, 1'b0, 8'h00, 1'b1);
        apply_stimulus(0, 1'b1, 8'h55, 1'b0);
        check_output("ovf_sticky", ovf0, 1);
        check_output("udf_sticky", udf0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("ovf_clr", ovf0, 0);
        check_output("udf_clr", udf0, 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        for (int i = 0; i < 400; i++) begin
            w = (i < 200) ? ($urandom_range(0, 99) < 65) : ($urandom_range(0, 99) < 35);
            r = (i < 200) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 65);
            apply_stimulus(0, w, 8'($urandom), r);
        end

        nw = 0;
        guard = 0;
        while (nw < 20 && guard < 500) begin
            w = $urandom_range(0, 99) < 60;
            r = $urandom_range(0, 99) < 50;
            if (w && m_size(1) != 5) nw++;
            apply_stimulus(1, w, 8'($urandom), r);
            guard++;
        end
        check_output("wrap_writes", nw >= 20, 1);
        repeat (6) apply_stimulus(1, 1'b0, 8'h00, 1'b1);
        check_output("wrap_drained", level1, 0);
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(1, $urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_lvl.md
Name: sync_fifo_lvl

Overview:
Single-clock, parametrised FIFO for intra-domain buffering between the register file, ALU and UART TX path. It is the successor to the two-clock FIFO and removes the pointer synchronisers.
- Generalised to any depth of 2 or more, not only powers of two.
- Adds a fill-level output, programmable almost-full/almost-empty flags, and optional sticky error flags.

Parameters:
- FIFO_WIDTH, 8, data word width in bits.
- FIFO_DEPTH, 8, number of entries; any integer of 2 or more.
- AF_THRESH, 6, ALMOST_FULL asserts when LEVEL >= AF_THRESH; legal range 1..FIFO_DEPTH.
- AE_THRESH, 2, ALMOST_EMPTY asserts when LEVEL <= AE_THRESH; legal range 0..FIFO_DEPTH-1.

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- W_INC  in  1  write request.
- WR_DATA  in  FIFO_WIDTH  write data.
- R_INC  in  1  read request.
- RD_DATA  out  FIFO_WIDTH  registered read data.
- FULL  out  1  LEVEL == FIFO_DEPTH.
- EMPTY  out  1  LEVEL == 0.
- ALMOST_FULL  out  1  LEVEL >= AF_THRESH.
- ALMOST_EMPTY  out  1  LEVEL <= AE_THRESH.
- LEVEL  out  CNT_W  number of stored entries; CNT_W = clog2(FIFO_DEPTH+1).
- OVERFLOW  out  1  sticky error flag; present only with the optional feature.
- UNDERFLOW  out  1  sticky error flag; present only with the optional feature.

Behaviour:
- Clock and reset:
  - One clock (CLK).
  - Asynchronous, active-low reset (RST).
- Reset (RST low, asynchronous):
  - Write/read pointers, LEVEL and RD_DATA all cleared to 0.
  - EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0 (ALMOST_EMPTY=1 since AE_THRESH >= 0).
  - OVERFLOW=0, UNDERFLOW=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all contents immediately; the first edge after deassertion behaves as from empty.
- Accept rules:
  - wr_acc = W_INC & ~FULL.
  - rd_acc = R_INC & ~EMPTY.
  - Both are evaluated on the flags as registered before the edge.
- Write: on wr_acc, mem[wptr] <= WR_DATA; wptr advances.
- Read:
  - On rd_acc, RD_DATA <= mem[rptr] at the same edge, i.e. valid the cycle after R_INC; rptr advances.
  - RD_DATA holds its value when no read is accepted.
- Pointer wrap: each pointer is PTR_W = clog2(FIFO_DEPTH) bits and wraps from FIFO_DEPTH-1 to 0 (explicit compare, not a power-of-two rollover).
- LEVEL update:
  - wr_acc & ~rd_acc: +1.
  - rd_acc & ~wr_acc: -1.
  - both or neither: unchanged.
- Flag decode: all flags are registered, decoded from the next-state LEVEL, so they change in the same cycle as LEVEL with no extra latency.
- Simultaneous W_INC & R_INC:
  - When full: read accepted, write dropped; FULL deasserts next cycle.
  - When empty: write accepted, read ignored; no bypass, so RD_DATA is unchanged and EMPTY deasserts next cycle.
  - Otherwise: both accepted, LEVEL unchanged.
- No state machine beyond the pointer/level counters; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - OVERFLOW sets on W_INC & FULL.
  - UNDERFLOW sets on R_INC & EMPTY.
  - Both are sticky until RST.
  - Flags update one cycle after the offending request.
- Undefined: both ports are absent and no logic is generated.

Decomposition:
- Shared package/header fifo_pkg:
  - clog2 constant function.
  - CNT_W / PTR_W derivation.
  - Reset-value constants.
- One natural sub-module, sync_fifo_mem:
  - FIFO_WIDTH x FIFO_DEPTH register array.
  - Synchronous write port and registered read port with enable.
  - Instantiated once; pointer/level/flag control stays in the top module.

Test Plan:
- Reset, then 8 writes of 0x11..0x88 (DEPTH=8, AF=6, AE=2):
  - ALMOST_EMPTY drops at LEVEL=3.
  - ALMOST_FULL rises at LEVEL=6.
  - FULL=1 at LEVEL=8.
  - A 9th write is dropped and LEVEL stays 8.
- From full, 8 reads: RD_DATA = 0x11..0x88, each one cycle after R_INC; EMPTY=1 after the last; a 9th read leaves RD_DATA=0x88.
- Set FIFO_DEPTH=5 and stream 20 writes interleaved with reads so pointers wrap 4->0 several times:
  - Output order matches input order.
  - LEVEL never exceeds 5.
- Simultaneous W_INC & R_INC with LEVEL=3: LEVEL stays 3 and data order is preserved.
- Simultaneous W_INC & R_INC at full: LEVEL becomes 7.
- Simultaneous W_INC & R_INC at empty: LEVEL becomes 1 and RD_DATA is unchanged.
- Assert RST mid-stream with LEVEL=4: outputs reach reset values without waiting for a clock edge; after release, a write of 0xA5 then a read returns 0xA5.
- With SYNC_FIFO_ERR_FLAGS_EN:
  - Write at full sets OVERFLOW.
  - Read at empty sets UNDERFLOW.
  - Both stay set through later normal traffic until RST.
